// File: rtl/regfile_dump_reader.sv
// Walks a register file read port from First_Addr to Last_Addr (wrapping modulo
// the depth) and streams each (address, data) pair out through a valid/ready port.
module regfile_dump_reader #(
    parameter int RegAdd_WIDTH  = 5,
    parameter int RegFile_WIDTH = 32,
    parameter int RegFile_DEPTH = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Start,
    input  logic                     Abort,
    input  logic [RegAdd_WIDTH-1:0]  First_Addr,
    input  logic [RegAdd_WIDTH-1:0]  Last_Addr,
    output logic [RegAdd_WIDTH-1:0]  Rd_Addr,
    input  logic [RegFile_WIDTH-1:0] Rd_Data,
    output logic [RegFile_WIDTH-1:0] Out_Data,
    output logic [RegAdd_WIDTH-1:0]  Out_Addr,
    output logic                     Out_Valid,
    input  logic                     Out_Ready,
    output logic                     Busy,
    output logic                     Done,
    output logic [1:0]               state_dbg
);

    // Output handshake: a word transfers on a CLK edge where Out_Valid and Out_Ready
    // are both high; while Out_Valid is high and Out_Ready is low, Out_Data and
    // Out_Addr hold. Out_Valid never drops without a transfer except on Abort/RST.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [RegAdd_WIDTH-1:0] TOP_ADDR = RegAdd_WIDTH'(RegFile_DEPTH - 1);

    state_t                    state;
    logic [RegAdd_WIDTH-1:0]   pointer;
    logic [RegAdd_WIDTH-1:0]   last_addr_q;
    logic [RegAdd_WIDTH-1:0]   next_pointer;

    assign next_pointer = (pointer == TOP_ADDR) ? '0 : pointer + 1'b1;
    assign state_dbg    = state;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            pointer     <= '0;
            last_addr_q <= '0;
            Rd_Addr     <= '0;
            Out_Data    <= '0;
            Out_Addr    <= '0;
            Out_Valid   <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    // Start wins over a simultaneous Abort; Abort alone is a no-op here.
                    if (Start) begin
                        pointer     <= First_Addr;
                        Rd_Addr     <= First_Addr;
                        last_addr_q <= Last_Addr;
                        Busy        <= 1'b1;
                        state       <= READ;
                    end
                end
                READ: begin
                    if (Abort) begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        Out_Data  <= Rd_Data;
                        Out_Addr  <= pointer;
                        Out_Valid <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (Abort) begin
                        Out_Valid <= 1'b0;
                        Busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (Out_Valid && Out_Ready) begin
                        Out_Valid <= 1'b0;
                        if (pointer == last_addr_q) begin
                            state <= DONE;
                        end else begin
                            pointer <= next_pointer;
                            Rd_Addr <= next_pointer;
                            state   <= READ;
                        end
                    end
                end
                DONE: begin
                    // Done is raised on the way out so an Abort here can still suppress it.
                    Busy  <= 1'b0;
                    Done  <= !Abort;
                    state <= IDLE;
                end
                default: begin
                    Out_Valid <= 1'b0;
                    Busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: behavioural register file plus a queue of the
// (address, data) words each dump must deliver, built from modular arithmetic.
module tb_regfile_dump_reader;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int EW    = AW + DW;

    // clock / reset
    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    always #5 CLK = ~CLK;

    logic          Start = 1'b0;
    logic          Abort = 1'b0;
    logic [AW-1:0] First_Addr = '0;
    logic [AW-1:0] Last_Addr  = '0;
    logic [AW-1:0] Rd_Addr;
    logic [DW-1:0] Rd_Data;
    logic [DW-1:0] Out_Data;
    logic [AW-1:0] Out_Addr;
    logic          Out_Valid;
    logic          Out_Ready = 1'b0;
    logic          Busy;
    logic          Done;
    logic [1:0]    state_dbg;

    logic [DW-1:0] regs [DEPTH];
    assign Rd_Data = regs[Rd_Addr];

    regfile_dump_reader #(
        .RegAdd_WIDTH (AW),
        .RegFile_WIDTH(DW),
        .RegFile_DEPTH(DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Start     (Start),
        .Abort     (Abort),
        .First_Addr(First_Addr),
        .Last_Addr (Last_Addr),
        .Rd_Addr   (Rd_Addr),
        .Rd_Data   (Rd_Data),
        .Out_Data  (Out_Data),
        .Out_Addr  (Out_Addr),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Busy      (Busy),
        .Done      (Done),
        .state_dbg (state_dbg)
    );

    // scoreboard
    logic [EW-1:0] exp_q [$];
    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic build_expected(input int first, input int last);
        int n;
        int a;
        exp_q.delete();
        n = ((last - first + DEPTH) % DEPTH) + 1;
        for (int k = 0; k < n; k++) begin
            a = (first + k) % DEPTH;
            exp_q.push_back({AW'(a), regs[a]});
        end
    endtask

    // driver: one whole dump, optionally stalled, aborted mid-stream or aborted in DONE
    task automatic run_dump(input int first, input int last, input int ready_pct,
                            input int stall, input int abort_word, input bit abort_done,
                            input bit check_timing, input bit abort_with_start);
        int n;
        int cyc;
        int hs;
        int stall_left;
        bit hs_now;
        bit stalled;
        logic [EW-1:0] front;
        build_expected(first, last);
        n = exp_q.size();
        First_Addr = AW'(first);
        Last_Addr  = AW'(last);
        Start      = 1'b1;
        Abort      = abort_with_start;
        Out_Ready  = 1'b0;
        step();
        Start = 1'b0;
        Abort = 1'b0;
        First_Addr = AW'($urandom);
        Last_Addr  = AW'($urandom);
        check("busy_after_start", Busy, 1);
        check("valid_in_read", Out_Valid, 0);
        cyc = 0;
        hs = 0;
        stall_left = stall;
        stalled = 0;
        while (exp_q.size() > 0 && cyc < 600) begin
            front = exp_q[0];
            if (stalled) check("stall_valid_held", Out_Valid, 1);
            if (Out_Valid) begin
                check("out_addr", Out_Addr, front[EW-1:DW]);
                check("out_data", Out_Data, front[DW-1:0]);
            end
            check("done_mid_dump", Done, 0);
            stalled = 0;
            if (Out_Valid && stall_left > 0) begin
                Out_Ready = 1'b0;
                stall_left--;
                stalled = 1;
            end else begin
                Out_Ready = ($urandom_range(99) < ready_pct);
            end
            Start = ($urandom_range(3) == 0);
            if (hs == abort_word && Out_Valid) begin
                Abort = 1'b1;
                Out_Ready = 1'b1;
            end
            hs_now = Out_Valid && Out_Ready;
            step();
            cyc++;
            Start = 1'b0;
            if (Abort) begin
                Abort = 1'b0;
                Out_Ready = 1'b0;
                check("abort_valid", Out_Valid, 0);
                check("abort_busy", Busy, 0);
                check("abort_state", state_dbg, 0);
                check("abort_no_done", Done, 0);
                step();
                check("abort_no_done_later", Done, 0);
                check("abort_stays_idle", Busy, 0);
                exp_q.delete();
                return;
            end
            if (hs_now) begin
                void'(exp_q.pop_front());
                hs++;
            end
        end
        Out_Ready = 1'b0;
        check("dump_words_left", exp_q.size(), 0);
        if (check_timing) check("last_handshake_cycle", cyc, 2 * n);
        check("done_state_valid", Out_Valid, 0);
        check("done_state_busy", Busy, 1);
        check("done_state_no_done_yet", Done, 0);
        if (abort_done) begin
            Abort = 1'b1;
            step();
            Abort = 1'b0;
            check("abort_in_done_no_done", Done, 0);
            check("abort_in_done_busy", Busy, 0);
            step();
            check("abort_in_done_no_done_later", Done, 0);
            return;
        end
        step();
        check("done_pulse", Done, 1);
        check("done_busy_low", Busy, 0);
        step();
        check("done_pulse_single", Done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) regs[i] = DW'(i * 4);

        // reset state
        step();
        step();
        check("rst_busy", Busy, 0);
        check("rst_valid", Out_Valid, 0);
        check("rst_done", Done, 0);
        check("rst_out_data", Out_Data, 0);
        check("rst_out_addr", Out_Addr, 0);
        check("rst_rd_addr", Rd_Addr, 0);
        check("rst_state", state_dbg, 0);
        RST = 1'b1;
        step();

        // Abort alone in IDLE is ignored
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        check("idle_abort_busy", Busy, 0);

        // full sweep at full rate with i*4 contents
        run_dump(0, 31, 100, 0, -1, 0, 1, 0);
        // wrap-around and single word
        run_dump(30, 1, 100, 0, -1, 0, 1, 0);
        run_dump(7, 7, 100, 0, -1, 0, 1, 0);
        // 5-cycle stall on first word
        run_dump(12, 14, 100, 5, -1, 0, 0, 0);
        // abort during SEND of word 3
        run_dump(0, 31, 100, 0, 3, 0, 0, 0);
        // abort while in DONE
        run_dump(4, 6, 100, 0, -1, 1, 0, 0);
        // Start beats a simultaneous Abort in IDLE
        run_dump(9, 9, 100, 0, -1, 0, 0, 1);

        // random contents, ranges and backpressure
        for (int i = 0; i < DEPTH; i++) regs[i] = $urandom;
        for (int t = 0; t < 6; t++) begin
            run_dump(int'($urandom_range(DEPTH - 1)), int'($urandom_range(DEPTH - 1)),
                     int'($urandom_range(30, 90)), 0, -1, 0, 0, 0);
        end

        // asynchronous reset in the middle of SEND
        First_Addr = 5'd2;
        Last_Addr  = 5'd20;
        Start = 1'b1;
        step();
        Start = 1'b0;
        step();
        check("pre_reset_valid", Out_Valid, 1);
        #2;
        RST = 1'b0;
        #1;
        check("async_rst_valid", Out_Valid, 0);
        check("async_rst_busy", Busy, 0);
        check("async_rst_out_data", Out_Data, 0);
        check("async_rst_out_addr", Out_Addr, 0);
        check("async_rst_rd_addr", Rd_Addr, 0);
        #3;
        RST = 1'b1;
        Out_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_idle", state_dbg, 0);
            check("post_rst_no_done", Done, 0);
            check("post_rst_no_valid", Out_Valid, 0);
        end
        Out_Ready = 1'b0;

        // a fresh Start still works after the reset
        run_dump(31, 0, 100, 0, -1, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
